// File: rtl/stump_control.sv
// Stump processor control unit: fetch/execute/memory sequencer and
// instruction decoder driving the register file, ALU, shifter and memory strobes.
module stump_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cc,
    input  logic [15:0] ir,
    output logic        fetch,
    output logic        execute,
    output logic        memory,
    output logic        ext_op,
    output logic        reg_write,
    output logic [2:0]  dest,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [1:0]  shift_op,
    output logic        opB_mux_sel,
    output logic [2:0]  alu_func,
    output logic        cc_en,
    output logic        mem_ren,
    output logic        mem_wen
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } state_t;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;
    localparam logic [2:0] PC_REG  = 3'd7;

    state_t state, next_state;

    logic [2:0] op;
    logic       imm_type;
    logic       s_bit;
    logic [2:0] dst;
    logic [2:0] reg_a;
    logic [2:0] reg_b;
    logic [1:0] sh;
    logic [3:0] cond;
    logic       flag_n, flag_z, flag_v, flag_c;
    logic       taken;

    assign op       = ir[15:13];
    assign imm_type = ir[12];
    assign s_bit    = ir[11];
    assign dst      = ir[10:8];
    assign reg_a    = ir[7:5];
    assign reg_b    = ir[4:2];
    assign sh       = ir[1:0];
    assign cond     = ir[11:8];
    assign {flag_n, flag_z, flag_v, flag_c} = cc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            4'h0: taken = 1'b1;
            4'h1: taken = 1'b0;
            4'h2: taken = ~flag_c & ~flag_z;
            4'h3: taken = flag_c | flag_z;
            4'h4: taken = ~flag_c;
            4'h5: taken = flag_c;
            4'h6: taken = ~flag_z;
            4'h7: taken = flag_z;
            4'h8: taken = ~flag_v;
            4'h9: taken = flag_v;
            4'hA: taken = ~flag_n;
            4'hB: taken = flag_n;
            4'hC: taken = (flag_n == flag_v);
            4'hD: taken = (flag_n != flag_v);
            4'hE: taken = ~flag_z & (flag_n == flag_v);
            4'hF: taken = flag_z | (flag_n != flag_v);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state  = state;
        fetch       = 1'b0;
        execute     = 1'b0;
        memory      = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        dest        = '0;
        srcA        = '0;
        srcB        = '0;
        shift_op    = '0;
        opB_mux_sel = 1'b0;
        alu_func    = '0;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;

        case (state)
            FETCH: begin
                next_state  = EXECUTE;
                fetch       = 1'b1;
                mem_ren     = 1'b1;
                reg_write   = 1'b1;
                dest        = PC_REG;
                srcA        = PC_REG;
                opB_mux_sel = 1'b1;
            end
            EXECUTE: begin
                next_state = (op == OP_LDST) ? MEMORY : FETCH;
                execute    = 1'b1;
                if (op == OP_BCC) begin
                    srcA        = PC_REG;
                    dest        = PC_REG;
                    opB_mux_sel = 1'b1;
                    ext_op      = 1'b1;
                    reg_write   = taken;
                end else begin
                    // LD/ST shares the ALU operand decode but only forms an address
                    srcA = reg_a;
                    if (op != OP_LDST) begin
                        alu_func  = op;
                        dest      = dst;
                        reg_write = 1'b1;
                        cc_en     = s_bit;
                    end
                    if (imm_type) begin
                        opB_mux_sel = 1'b1;
                        ext_op      = 1'b1;
                    end else begin
                        srcB     = reg_b;
                        shift_op = sh;
                    end
                end
            end
            MEMORY: begin
                next_state = FETCH;
                memory     = 1'b1;
                if (s_bit) begin
                    mem_wen = 1'b1;
                    srcA    = dst;
                end else begin
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                    dest      = dst;
                end
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: a behavioural decode model pushes the
// expected control vector to a scoreboard queue, which each test pops and compares.
module tb_stump_control;

    logic        clk;
    logic        rst;
    logic [3:0]  cc;
    logic [15:0] ir;
    logic        fetch, execute, memory, ext_op, reg_write;
    logic [2:0]  dest, srcA, srcB, alu_func;
    logic [1:0]  shift_op;
    logic        opB_mux_sel, cc_en, mem_ren, mem_wen;

    int unsigned passed;
    int unsigned total;

    typedef struct {
        string       tag;
        logic [22:0] v;
    } exp_t;

    exp_t sbq[$];

    stump_control dut (
        .clk(clk), .rst(rst), .cc(cc), .ir(ir),
        .fetch(fetch), .execute(execute), .memory(memory),
        .ext_op(ext_op), .reg_write(reg_write), .dest(dest),
        .srcA(srcA), .srcB(srcB), .shift_op(shift_op),
        .opB_mux_sel(opB_mux_sel), .alu_func(alu_func), .cc_en(cc_en),
        .mem_ren(mem_ren), .mem_wen(mem_wen)
    );

    logic [22:0] dut_v;
    assign dut_v = {fetch, execute, memory, ext_op, reg_write, dest, srcA, srcB,
                    shift_op, opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase: 0 = FETCH, 1 = EXECUTE, 2 = MEMORY
    function automatic logic [22:0] model(int ph, logic [15:0] i, logic [3:0] f);
        logic fe, ex, me, ext, rw, ob, cce, mr, mw;
        logic [2:0] d, sa, sbr, af;
        logic [1:0] so;
        logic n, z, v, c;
        logic [15:0] t;
        {fe, ex, me, ext, rw, ob, cce, mr, mw} = '0;
        d = '0; sa = '0; sbr = '0; af = '0; so = '0;
        {n, z, v, c} = f;
        t[0]  = 1'b1;           t[1]  = 1'b0;
        t[2]  = !c && !z;       t[3]  = c || z;
        t[4]  = !c;             t[5]  = c;
        t[6]  = !z;             t[7]  = z;
        t[8]  = !v;             t[9]  = v;
        t[10] = !n;             t[11] = n;
        t[12] = (n == v);       t[13] = (n != v);
        t[14] = !z && (n == v); t[15] = z || (n != v);
        if (ph == 0) begin
            fe = 1; mr = 1; rw = 1; d = 3'd7; sa = 3'd7; ob = 1;
        end else if (ph == 1) begin
            ex = 1;
            if (i[15:13] == 3'd7) begin
                sa = 3'd7; d = 3'd7; ob = 1; ext = 1; rw = t[i[11:8]];
            end else begin
                sa = i[7:5];
                if (i[15:13] != 3'd6) begin
                    af = i[15:13]; rw = 1; d = i[10:8]; cce = i[11];
                end
                if (i[12]) begin
                    ob = 1; ext = 1;
                end else begin
                    sbr = i[4:2]; so = i[1:0];
                end
            end
        end else begin
            me = 1;
            if (i[11]) begin
                mw = 1; sa = i[10:8];
            end else begin
                mr = 1; rw = 1; d = i[10:8];
            end
        end
        return {fe, ex, me, ext, rw, d, sa, sbr, so, ob, af, cce, mr, mw};
    endfunction

    task automatic push_exp(string tag, int ph);
        exp_t e;
        e.tag = tag;
        e.v   = model(ph, ir, cc);
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; ir = 16'h0000; cc = 4'h0;
        @(posedge clk); #1;
        push_exp("reset_state", 0);
        e = sbq.pop_front(); total++;
        if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_exp($sformatf("reset_cycle%0d", k), (k == 1) ? 1 : 0);
            @(negedge clk);
            e = sbq.pop_front(); total++;
            if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
            else passed++;
            @(posedge clk); #1;
        end
        // Leave the DUT in FETCH after the ir=0 instruction's EXECUTE
        push_exp("reset_exec2", 1);
        @(negedge clk);
        e = sbq.pop_front(); total++;
        if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_sweep();
        exp_t e;
        logic [10:0] low;
        for (int p = 0; p < 4; p++) begin
            for (int ot = 0; ot < 16; ot++) begin
                logic [3:0] otv;
                int ph;
                otv = ot[3:0];
                low = (p < 2) ? 11'd0 : 11'($urandom);
                ir  = {otv, p[0], low};
                cc  = 4'($urandom);
                ph  = 0;
                while (1) begin
                    push_exp($sformatf("sweep_p%0d_ir%h_ph%0d", p, ir, ph), ph);
                    @(negedge clk);
                    e = sbq.pop_front(); total++;
                    if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
                    else passed++;
                    if (ph == 1 && otv[3:1] < 3'd6) begin
                        total++;
                        if ({reg_write, cc_en, opB_mux_sel, ext_op} !== {1'b1, p[0], otv[0], otv[0]})
                            $display("FAIL alu_ctrl ir=%h: got %b expected %b", ir,
                                     {reg_write, cc_en, opB_mux_sel, ext_op},
                                     {1'b1, p[0], otv[0], otv[0]});
                        else passed++;
                    end
                    @(posedge clk); #1;
                    if (ph == 0) ph = 1;
                    else if (ph == 1 && otv[3:1] == 3'd6) ph = 2;
                    else break;
                end
            end
        end
    endtask

    task automatic test_load_store(logic [15:0] instr, string name);
        exp_t e;
        ir = instr; cc = 4'($urandom);
        for (int ph = 0; ph < 3; ph++) begin
            push_exp($sformatf("%s_ph%0d", name, ph), ph);
            @(negedge clk);
            e = sbq.pop_front(); total++;
            if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
            else passed++;
            if (ph == 2) begin
                total++;
                if (instr[11] == 1'b0 &&
                    {memory, mem_ren, mem_wen, reg_write, dest} !== {4'b1101, instr[10:8]})
                    $display("FAIL %s_mem: got %b expected %b", name,
                             {memory, mem_ren, mem_wen, reg_write, dest}, {4'b1101, instr[10:8]});
                else if (instr[11] == 1'b1 &&
                         {memory, mem_ren, mem_wen, reg_write, srcA} !== {4'b1010, instr[10:8]})
                    $display("FAIL %s_mem: got %b expected %b", name,
                             {memory, mem_ren, mem_wen, reg_write, srcA}, {4'b1010, instr[10:8]});
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(logic [15:0] instr, logic [3:0] flags, logic exp_rw);
        exp_t e;
        ir = instr; cc = flags;
        for (int ph = 0; ph < 2; ph++) begin
            push_exp($sformatf("bcc_ir%h_cc%h_ph%0d", instr, flags, ph), ph);
            @(negedge clk);
            e = sbq.pop_front(); total++;
            if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
            else passed++;
            if (ph == 1) begin
                total++;
                if ({reg_write, dest, cc_en} !== {exp_rw, 3'd7, 1'b0})
                    $display("FAIL bcc_taken ir=%h cc=%h: got %b expected %b", instr, flags,
                             {reg_write, dest, cc_en}, {exp_rw, 3'd7, 1'b0});
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cond_sweep();
        for (int cd = 0; cd < 16; cd++) begin
            logic [3:0] cdv;
            logic [3:0] fl;
            cdv = cd[3:0];
            fl  = 4'($urandom);
            ir  = {4'b1110, cdv, 8'($urandom)};
            cc  = fl;
            for (int ph = 0; ph < 2; ph++) begin
                exp_t e;
                push_exp($sformatf("cond%0d_cc%h_ph%0d", cd, fl, ph), ph);
                @(negedge clk);
                e = sbq.pop_front(); total++;
                if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
                else passed++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        ir = 16'hC800; cc = 4'h0;
        for (int ph = 0; ph < 3; ph++) begin
            push_exp($sformatf("arst_ph%0d", ph), ph);
            #2;
            e = sbq.pop_front(); total++;
            if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
            else passed++;
            if (ph < 2) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        #1;
        push_exp("arst_immediate", 0);
        e = sbq.pop_front(); total++;
        if (dut_v !== e.v || mem_wen !== 1'b0)
            $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
        else passed++;
        @(posedge clk); #1;
        push_exp("arst_held", 0);
        e = sbq.pop_front(); total++;
        if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
        else passed++;
        rst = 1'b0;
        ir  = 16'h0000;
        for (int ph = 0; ph < 2; ph++) begin
            push_exp($sformatf("arst_resume_ph%0d", ph), ph);
            @(negedge clk);
            e = sbq.pop_front(); total++;
            if (dut_v !== e.v) $display("FAIL %s: got %h expected %h", e.tag, dut_v, e.v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; ir = '0; cc = '0;
        test_reset();
        test_alu_sweep();
        test_load_store(16'hC000, "load");
        test_load_store(16'hC800, "store");
        test_load_store(16'hC5A3, "load_r5");
        test_load_store(16'hDE6C, "store_r6");
        test_branch(16'hE000, 4'h0, 1'b1);
        test_branch(16'hE100, 4'hF, 1'b0);
        test_branch(16'hE700, 4'b0100, 1'b1);
        test_branch(16'hE700, 4'b0000, 1'b0);
        test_cond_sweep();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
